trig_event_capture: RTL and testbench



---
 rtl/trig_event_capture.sv | 120 ++++++++++++
 tb/tb_trig_event_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_event_capture.sv
// Turns each rising qualified trigger into one {count, gap} record in a single-entry valid/ready slot.
// Build option: define TRIG_EVT_GAP_EN to include the inter-event gap timer (otherwise evt_gap is 0).
module trig_event_capture #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic [GAP_W-1:0] evt_gap,
  output logic             overflow,
  output logic             armed
);

  localparam logic [0:0] ST_ARMED = 1'b0;
  localparam logic [0:0] ST_FIRED = 1'b1;

  logic             trig_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic             overflow_q, overflow_d;
  logic             edge_det;
  logic             load;

  // Registered trigger gives the one-cycle detection latency and isolates the input.
  assign edge_det = (state_q == ST_ARMED) && trig_q;
  assign load     = edge_det && !clear && (!evt_valid_q || evt_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: if (trig_q)  state_d = ST_FIRED;
      default:  if (!trig_q) state_d = ST_ARMED;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    evt_valid_d = evt_valid_q;
    evt_count_d = evt_count_q;
    overflow_d  = overflow_q;
    if (clear) begin
      cnt_d       = '0;
      evt_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (edge_det) cnt_d = cnt_q + 1'b1;
      if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
      if (load) begin
        evt_valid_d = 1'b1;
        evt_count_d = cnt_q + 1'b1;
      end
      // Dropped records still advance cnt, so the count gap exposes the loss.
      if (edge_det && evt_valid_q && !evt_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= 1'b0;
      state_q     <= ST_ARMED;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      trig_q      <= trigger;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_count_q <= evt_count_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef TRIG_EVT_GAP_EN
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] evt_gap_q, evt_gap_d;

  // All-ones doubles as "no previous event" and "saturated".
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    evt_gap_d = evt_gap_q;
    if (clear) begin
      gap_cnt_d = '1;
    end else if (edge_det) begin
      gap_cnt_d = GAP_W'(1);
    end else if (gap_cnt_q != '1) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
    if (load) evt_gap_d = gap_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '1;
      evt_gap_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      evt_gap_q <= evt_gap_d;
    end
  end

  assign evt_gap = evt_gap_q;
`else
  assign evt_gap = '0;
`endif

  assign evt_valid = evt_valid_q;
  assign evt_count = evt_count_q;
  assign overflow  = overflow_q;
  assign armed     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_trig_event_capture.sv
// Bench for trig_event_capture: scenario tasks plus a record scoreboard popped on each accepted record.
module tb_trig_event_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        clear = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [7:0]  evt_count;
  logic [15:0] evt_gap;
  logic        overflow;
  logic        armed;

  typedef struct packed {
    logic [7:0]  cnt;
    logic [15:0] gap;
  } rec_t;

  rec_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_det = -1;
  logic [7:0] cnt_m = 8'd0;

  trig_event_capture #(.CNT_W(8), .GAP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count),
    .evt_gap(evt_gap), .overflow(overflow), .armed(armed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_gap(input logic [15:0] g);
`ifdef TRIG_EVT_GAP_EN
    return g;
`else
    return 16'd0 & g;
`endif
  endfunction

  function automatic logic [15:0] gap_of(input int det);
    if (last_det < 0 || (det - last_det) >= 65535) return exp_gap(16'hFFFF);
    return exp_gap(16'(det - last_det));
  endfunction

  // One clock; accepted records are popped against the queue at the negedge.
  task automatic step();
    rec_t r;
    @(negedge clk);
    if (rst_n && evt_valid && evt_ready) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got count=%0d gap=%0h, expected no record", evt_count, evt_gap);
      end else begin
        r = sbq.pop_front();
        if ({evt_count, evt_gap} !== r) begin
          n_err++;
          $display("FAIL sb_record: got count=%0d gap=%0h, expected count=%0d gap=%0h",
                   evt_count, evt_gap, r.cnt, r.gap);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic note_edge(input bit push);
    rec_t r;
    int   det;
    det   = cyc + 1;
    cnt_m = cnt_m + 8'd1;
    r.cnt = cnt_m;
    r.gap = gap_of(det);
    last_det = det;
    if (push) sbq.push_back(r);
  endtask

  task automatic fire(input int hi, input int lo, input bit push);
    note_edge(push);
    trigger = 1'b1;
    repeat (hi) step();
    trigger = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt_m = 8'd0;
    last_det = -1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++; if (armed !== 1'b1)     begin n_err++; $display("FAIL rst_armed: got %b expected 1", armed); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", evt_valid); end
    n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", evt_count); end
    n_cmp++; if (evt_gap !== 16'd0)  begin n_err++; $display("FAIL rst_gap: got %0h expected 0", evt_gap); end
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_held();
    evt_ready = 1'b1;
    note_edge(1);
    trigger = 1'b1;
    step();
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b expected 0", evt_valid); end
    step();
    n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", evt_valid); end
    n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", evt_count); end
    n_cmp++; if (evt_gap !== exp_gap(16'hFFFF)) begin n_err++; $display("FAIL single_gap: got %0h expected %0h", evt_gap, exp_gap(16'hFFFF)); end
    n_cmp++; if (armed !== 1'b0)     begin n_err++; $display("FAIL single_armed: got %b expected 0", armed); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_held_%0d: got valid %b expected 0", i, evt_valid); end
    end
    trigger = 1'b0;
    repeat (3) step();
    n_cmp++; if (armed !== 1'b1) begin n_err++; $display("FAIL single_rearm: got %b expected 1", armed); end
  endtask

  task automatic test_gap();
    do_clear();
    evt_ready = 1'b1;
    fire(1, 14, 1);
    note_edge(1);
    trigger = 1'b1;
    repeat (2) step();
    n_cmp++; if (evt_count !== 8'd2) begin n_err++; $display("FAIL gap_count: got %0d expected 2", evt_count); end
    n_cmp++; if (evt_gap !== exp_gap(16'd15)) begin n_err++; $display("FAIL gap_value: got %0d expected %0d", evt_gap, exp_gap(16'd15)); end
    trigger = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_overflow();
    do_clear();
    evt_ready = 1'b0;
    fire(1, 2, 1);
    fire(1, 2, 0);
    fire(1, 2, 0);
    n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b expected 1", evt_valid); end
    n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL ovf_held_count: got %0d expected 1", evt_count); end
    n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    evt_ready = 1'b1;
    step();
    note_edge(1);
    trigger = 1'b1;
    repeat (2) step();
    n_cmp++; if (evt_count !== 8'd4) begin n_err++; $display("FAIL ovf_next_count: got %0d expected 4", evt_count); end
    n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    trigger = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    do_clear();
    evt_ready = 1'b0;
    fire(1, 2, 1);
    note_edge(1);
    trigger = 1'b1;
    step();
    n_cmp++; if (evt_valid !== 1'b1 || evt_count !== 8'd1) begin n_err++; $display("FAIL b2b_first: got valid %b count %0d expected 1/1", evt_valid, evt_count); end
    evt_ready = 1'b1;
    step();
    n_cmp++; if (evt_valid !== 1'b1 || evt_count !== 8'd2) begin n_err++; $display("FAIL b2b_second: got valid %b count %0d expected 1/2", evt_valid, evt_count); end
    trigger = 1'b0;
    step();
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", evt_valid); end
    step();
  endtask

  task automatic test_wrap();
    do_clear();
    evt_ready = 1'b1;
    repeat (255) fire(1, 1, 1);
    note_edge(1);
    trigger = 1'b1;
    repeat (2) step();
    n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL wrap_count: got %0d expected 0", evt_count); end
    n_cmp++; if (evt_gap !== exp_gap(16'd2)) begin n_err++; $display("FAIL wrap_gap: got %0d expected %0d", evt_gap, exp_gap(16'd2)); end
    trigger = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_clear_edge();
    evt_ready = 1'b0;
    fire(1, 2, 0);
    fire(1, 2, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_pre_ovf: got %b expected 1", overflow); end
    trigger = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt_m = 8'd0;
    last_det = -1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b expected 0", evt_valid); end
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
    n_cmp++; if (armed !== 1'b0)     begin n_err++; $display("FAIL clr_fsm_tracks: got armed %b expected 0", armed); end
    evt_ready = 1'b1;
    repeat (3) step();
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL clr_held_noevt: got %b expected 0", evt_valid); end
    trigger = 1'b0;
    repeat (2) step();
    note_edge(1);
    trigger = 1'b1;
    repeat (2) step();
    n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL clr_next_count: got %0d expected 1", evt_count); end
    trigger = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    trigger = 1'b1;
    repeat (2) step();
    n_cmp++; if (evt_valid !== 1'b1 || armed !== 1'b0) begin n_err++; $display("FAIL mid_pre: got valid %b armed %b expected 1/0", evt_valid, armed); end
    #2;
    rst_n = 1'b0;
    trigger = 1'b0;
    #1;
    n_cmp++; if (armed !== 1'b1)     begin n_err++; $display("FAIL mid_armed: got %b expected 1", armed); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b expected 0", evt_valid); end
    n_cmp++; if (evt_count !== 8'd0) begin n_err++; $display("FAIL mid_count: got %0d expected 0", evt_count); end
    n_cmp++; if (evt_gap !== 16'd0)  begin n_err++; $display("FAIL mid_gap: got %0h expected 0", evt_gap); end
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    rst_n = 1'b1;
    cnt_m = 8'd0;
    last_det = -1;
    repeat (2) step();
    evt_ready = 1'b1;
    note_edge(1);
    trigger = 1'b1;
    repeat (2) step();
    n_cmp++; if (evt_count !== 8'd1) begin n_err++; $display("FAIL mid_next_count: got %0d expected 1", evt_count); end
    n_cmp++; if (evt_gap !== exp_gap(16'hFFFF)) begin n_err++; $display("FAIL mid_next_gap: got %0h expected %0h", evt_gap, exp_gap(16'hFFFF)); end
    trigger = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single_held();
    test_gap();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_clear_edge();
    test_reset_mid();
    repeat (3) step();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d records still expected, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
